// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional feature macro: MULT_DIV_UNSIGNED_EN (adds the unsgn port for multu/divu).
package mult_div_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic [WIDTH-1:0] negate_if(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div_datapath.sv
// 64-bit accumulator/remainder shift register with one radix-2 multiply or
// restoring-divide step per enabled clock.
module mult_div_datapath
    import mult_div_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 op,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    // Multiply: low half holds the remaining multiplier bits, product grows in from the top.
    // Divide: low half holds the dividend shifting out and the quotient shifting in.
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, opnd_q};
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
        end else if (step) begin
            if (op == OP_MULT) begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end else if (diff[WIDTH]) begin
                acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mult_div_ctrl.sv
// Signed 32-bit iterative multiply/divide controller (IDLE/CALC/FIX/DONE).
// Optional feature macro: MULT_DIV_UNSIGNED_EN adds the unsgn input for multu/divu.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             unsgn,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mult_div_pkg::*;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               use_sign;
    logic               accept;
    logic               div_by_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;

`ifdef MULT_DIV_UNSIGNED_EN
    assign use_sign = ~unsgn;
`else
    assign use_sign = 1'b1;
`endif

    assign accept      = (state_q == S_IDLE) && start;
    assign div_by_zero = (op == OP_DIV) && (b == '0);
    assign a_mag       = negate_if(use_sign & a[WIDTH-1], a);
    assign b_mag       = negate_if(use_sign & b[WIDTH-1], b);
    assign product     = (a_neg_q ^ b_neg_q) ? (~acc + 1'b1) : acc;

    mult_div_datapath u_datapath (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .step  (state_q == S_CALC),
        .op    (op_q),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .acc   (acc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // A divide by zero bypasses the iterations entirely and only raises the flag.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = div_by_zero ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == LAST_ITER) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (accept) begin
            cnt_d   = '0;
            op_d    = op;
            a_neg_d = use_sign & a[WIDTH-1];
            b_neg_d = use_sign & b[WIDTH-1];
            dz_d    = div_by_zero;
        end
        if (state_q == S_CALC) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Remainder follows the dividend sign; quotient and product follow the sign mismatch.
        if (state_q == S_FIX) begin
            if (op_q == OP_MULT) begin
                hi_d = product[2*WIDTH-1:WIDTH];
                lo_d = product[WIDTH-1:0];
            end else begin
                hi_d = negate_if(a_neg_q, acc[2*WIDTH-1:WIDTH]);
                lo_d = negate_if(a_neg_q ^ b_neg_q, acc[WIDTH-1:0]);
            end
        end
    end

    always_comb begin
        busy     = (state_q == S_CALC) || (state_q == S_FIX);
        done     = (state_q == S_DONE);
        div_zero = (state_q == S_DONE) && dz_q;
        hi       = hi_q;
        lo       = lo_q;
    end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 supported.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  1  0 = mult, 1 = div.
REQ-006 a  input  32  multiplicand / dividend; latched at accept.
REQ-007 b  input  32  multiplier / divisor; latched at accept.
REQ-008 busy  output  1  high while in CALC or FIX.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 div_zero  output  1  high with done when a div had b = 0.
REQ-011 hi  output  32  product[63:32] or remainder; held until next completion.
REQ-012 lo  output  32  product[31:0] or quotient; held until next completion.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE.
REQ-014 Transitions:
- IDLE->CALC: start = 1 at the edge.
- CALC->FIX: after 32 iteration edges.
- FIX->DONE: next edge.
- DONE->IDLE: next edge.
REQ-015 Accept at edge N: latch magnitudes of a and b plus both sign bits, clear the iteration counter; busy is high from N+1.
REQ-016 CALC performs one radix-2 step per edge: shift-add for mult, restoring shift-subtract for div; 5-bit counter.
REQ-017 FIX, edge N+33: apply sign correction and write hi/lo; done is high for exactly the cycle between N+33 and N+34.
REQ-018 Sign rules:
- Product is negated when operand signs differ.
- Quotient is negated when signs differ.
- Remainder takes the dividend's sign.
REQ-019 Overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0; no flag.
REQ-020 Div with b = 0 at accept: skip CALC/FIX and go IDLE->DONE at edge N; done and div_zero high in the following cycle; hi/lo unchanged.
REQ-021 start outside IDLE is ignored; no queuing.
REQ-022 op, a and b are don't-care except at the accept edge.
REQ-023 div_zero is low whenever done is low.

Reset
REQ-024 reset = 0 at a rising edge: state IDLE, counter 0, busy = done = div_zero = 0, hi = lo = 0.
REQ-025 Reset mid-operation aborts with no done pulse and no hi/lo update; start is accepted on the first edge with reset = 1.

Configuration
REQ-026 Macro MULT_DIV_UNSIGNED_EN:
- Defined: adds input port unsgn (1 bit, latched at accept); unsgn = 1 skips the REQ-018 sign handling, giving multu/divu.
- Undefined: port absent; all operations are signed.
- The div-by-zero rule applies in both modes.

Structure
REQ-027 Shared package mult_div_pkg holds the state enum, OP_MULT/OP_DIV constants, WIDTH and ITER_COUNT = 32.
REQ-028 The FSM lives in mult_div_ctrl.
REQ-029 One sub-module, mult_div_datapath, holds the 64-bit accumulator/remainder shift register and the single-step add/subtract logic; it is driven by step/op/load controls from the FSM.

Verification
REQ-030 mult a = 7, b = 0xFFFFFFFD -> done at N+33..N+34, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, div_zero = 0.
REQ-031 div a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-032 div a = 5, b = 0 after a prior result (hi = 1, lo = 2) -> done and div_zero high in cycle after N; hi = 1, lo = 2; busy never high.
REQ-033 mult 0x80000000 x 0x80000000 with start re-pulsed at N+5 -> hi = 0x40000000, lo = 0, exactly one done; second start ignored.
REQ-034 div 100 / 7, reset low at N+10 -> busy = 0, hi = lo = 0 next cycle, no done; a new div 100 / 7 then gives lo = 14, hi = 2.
REQ-035 With MULT_DIV_UNSIGNED_EN, unsgn = 1, div 0xFFFFFFFF / 2 -> lo = 0x7FFFFFFF, hi = 1.
